// File: rtl/fpu_issue_decode.sv
// FPU coprocessor issue front-end: instruction queue, head decode, rounding-mode resolve, illegal drop.
// Define FPU_SCOREBOARD_EN to build the integer-destination scoreboard and its issue stall.
module fpu_issue_decode #(
    parameter int DEPTH = 4,
    parameter int FLEN  = 16
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [31:0] iss_instr,
    output logic [2:0]  iss_class,
    output logic [4:0]  iss_rd,
    output logic [4:0]  iss_rs1,
    output logic [4:0]  iss_rs2,
    output logic [2:0]  iss_rm,
    input  logic [2:0]  frm,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic [31:0] sb_pending,
    output logic        illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;
    localparam logic [6:0] OP_FP    = 7'b1010011;
    localparam logic [6:0] OP_FMADD = 7'b1000011;
    localparam logic [6:0] OP_FMSUB = 7'b1000111;
    localparam logic [6:0] OP_FNMSB = 7'b1001011;
    localparam logic [6:0] OP_FNMAD = 7'b1001111;
    localparam logic [6:0] OP_RST   = 7'b0010000;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          illegal_q;

    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic          hazard;
    logic [31:0]   head;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    funct5;
    logic [1:0]    fmt;
    logic [2:0]    cls;
    logic          fp_op;
    logic          fmt_ok;
    logic          rnd_applies;
    logic          frm_bad;

    // Head view: forced to zero while empty so every iss_* field reads 0.
    assign empty  = (count == '0);
    assign head   = empty ? 32'd0 : mem[rd_ptr];
    assign opcode = head[6:0];
    assign funct3 = head[14:12];
    assign funct5 = head[31:27];
    assign fmt    = head[26:25];

    always_comb begin
        cls = 3'd0;
        case (opcode)
            OP_ADDI:                               cls = 3'd1;
            OP_LUI:                                cls = 3'd2;
            OP_CSR:                                cls = 3'd3;
            OP_FP:                                 cls = 3'd4;
            OP_FMADD, OP_FMSUB, OP_FNMSB, OP_FNMAD: cls = 3'd5;
            OP_RST:                                cls = 3'd6;
            default:                               cls = 3'd0;
        endcase
    end

    assign fp_op   = (cls == 3'd4) || (cls == 3'd5);
    assign fmt_ok  = (fmt == 2'b10) || ((FLEN == 32) && (fmt == 2'b00));
    assign frm_bad = (frm == 3'b101) || (frm == 3'b110) || (frm == 3'b111);

    // funct3 is a rounding mode only for fused ops and arithmetic/convert OP-FP;
    // for sign-inject, min/max, compare, move and classify it selects the sub-op.
    assign rnd_applies = (cls == 3'd5) ||
                         ((cls == 3'd4) && (funct5 inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                                           5'b01000, 5'b01011, 5'b11000, 5'b11010}));

    assign drop = !empty && fp_op &&
                  (!fmt_ok ||
                   ((funct3 == 3'b111) && frm_bad) ||
                   (rnd_applies && ((funct3 == 3'b101) || (funct3 == 3'b110))));

    assign in_ready  = (count != CW'(DEPTH));
    assign iss_valid = !empty && !drop && !hazard;
    assign push      = in_valid && in_ready;
    assign pop       = (iss_valid && iss_ready) || drop;

    assign iss_instr = head;
    assign iss_class = cls;
    assign iss_rd    = head[11:7];
    assign iss_rs1   = head[19:15];
    assign iss_rs2   = head[24:20];
    assign iss_rm    = !fp_op ? 3'b000 : ((funct3 == 3'b111) ? frm : funct3);
    assign illegal   = illegal_q;

    // Queue control: flush wins over push and pop, and suppresses the drop pulse.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            illegal_q <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_instr;
    end

`ifdef FPU_SCOREBOARD_EN
    logic [31:0] sb_q;
    logic [31:0] sb_d;
    logic        issue_fire;
    logic        int_wr;
    logic        int_src;

    assign issue_fire = iss_valid && iss_ready && !flush;
    assign int_wr     = (cls == 3'd4) && (funct5 inside {5'b10100, 5'b11000, 5'b11100});
    assign int_src    = (cls == 3'd1) ||
                        ((cls == 3'd3) && (funct3 == 3'b001)) ||
                        ((cls == 3'd4) && (funct5 inside {5'b11010, 5'b11110}));
    assign hazard     = (int_src && sb_q[iss_rs1]) || ((iss_rd != 5'd0) && sb_q[iss_rd]);

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) sb_d[wb_rd] = 1'b0;
        if (issue_fire && int_wr && (iss_rd != 5'd0)) sb_d[iss_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    assign sb_pending = sb_q;
`else
    logic unused_wb;
    assign unused_wb  = ^{wb_valid, wb_rd};
    assign hazard     = 1'b0;
    assign sb_pending = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_decode.sv
// Directed bench for fpu_issue_decode (DEPTH=4, FLEN=16); scoreboard expectations follow FPU_SCOREBOARD_EN.
`timescale 1ns/1ps
module tb_fpu_issue_decode;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic        flush = 1'b0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [31:0] iss_instr;
    logic [2:0]  iss_class;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [2:0]  iss_rm;
    logic [2:0]  frm = 3'd0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] sb_pending;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] FADD_S   = 32'h0020F0D3;
    localparam logic [31:0] FADD_H   = 32'h0420F0D3;
    localparam logic [31:0] FADD_RM5 = 32'h0420D0D3;
    localparam logic [31:0] FMADD_H  = 32'h1C209443;
    localparam logic [31:0] FEQ_H_X5 = 32'hA420A2D3;
    localparam logic [31:0] FLT_H_X7 = 32'hA42093D3;
    localparam logic [31:0] ADDI_X6  = 32'h00128313;
`ifdef FPU_SCOREBOARD_EN
    localparam logic [31:0] SB7 = 32'h0000_0080;
`else
    localparam logic [31:0] SB7 = 32'h0000_0000;
`endif

    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [2:0]  bc [5];

    always #5 clk = ~clk;

    fpu_issue_decode #(.DEPTH(4), .FLEN(16)) dut (
        .clk(clk), .rst_l(rst_l),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
        .iss_class(iss_class), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rm(iss_rm), .frm(frm),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .sb_pending(sb_pending), .illegal(illegal)
    );

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({in_ready, iss_valid, illegal, iss_instr, iss_class, iss_rm, sb_pending} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b ill=%b instr=%h cls=%0d rm=%0d sb=%h",
                     in_ready, iss_valid, illegal, iss_instr, iss_class, iss_rm, sb_pending);
        end
        @(negedge clk);
        rst_l = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, iss_valid, iss_rd, iss_rs1, iss_rs2} !== {1'b1, 1'b0, 15'd0}) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b vld=%b rd=%0d rs1=%0d rs2=%0d want 1 0 0 0 0",
                     in_ready, iss_valid, iss_rd, iss_rs1, iss_rs2);
        end
    endtask

    task automatic test_fill_order();
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = a[i];
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready);
            end
        end
        @(negedge clk);
        in_instr = a[4];
        #1;
        n_cmp++;
        if ({in_ready, iss_valid, iss_instr} !== {1'b0, 1'b1, a[0]}) begin
            n_bad++;
            $display("FAIL full_block: got rdy=%b vld=%b instr=%h want 0 1 %h", in_ready, iss_valid, iss_instr, a[0]);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({in_ready, iss_valid, iss_instr} !== {1'b0, 1'b1, a[0]}) begin
            n_bad++;
            $display("FAIL head_stable: got rdy=%b vld=%b instr=%h want 0 1 %h", in_ready, iss_valid, iss_instr, a[0]);
        end
        @(negedge clk);
        iss_ready = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, iss_valid, iss_instr} !== {1'b0, 1'b1, a[0]}) begin
            n_bad++;
            $display("FAIL full_pop_no_push: got rdy=%b vld=%b instr=%h want 0 1 %h", in_ready, iss_valid, iss_instr, a[0]);
        end
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) in_valid = 1'b0;
            #1;
            n_cmp++;
            if ({iss_valid, iss_instr} !== {1'b1, a[k]}) begin
                n_bad++;
                $display("FAIL issue_order_%0d: got vld=%b instr=%h want 1 %h", k, iss_valid, iss_instr, a[k]);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({iss_valid, in_ready, iss_instr} !== {1'b0, 1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL drained: got vld=%b rdy=%b instr=%h want 0 1 0", iss_valid, in_ready, iss_instr);
        end
    endtask

    task automatic test_flen();
        @(negedge clk);
        iss_ready = 1'b1;
        frm = 3'b000;
        in_valid = 1'b1;
        in_instr = FADD_S;
        @(negedge clk);
        in_instr = FADD_H;
        #1;
        n_cmp++;
        if ({iss_valid, illegal} !== 2'b00) begin
            n_bad++;
            $display("FAIL fadd_s_head: got vld=%b ill=%b want 0 0", iss_valid, illegal);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL fadd_s_illegal: got %b want 1", illegal);
        end
        n_cmp++;
        if ({iss_valid, iss_class, iss_rm, iss_rd, iss_rs1, iss_rs2} !==
            {1'b1, 3'd4, 3'd0, 5'd1, 5'd1, 5'd2}) begin
            n_bad++;
            $display("FAIL fadd_h_issue: got vld=%b cls=%0d rm=%0d rd=%0d rs1=%0d rs2=%0d want 1 4 0 1 1 2",
                     iss_valid, iss_class, iss_rm, iss_rd, iss_rs1, iss_rs2);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({illegal, iss_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL illegal_one_cycle: got ill=%b vld=%b want 0 0", illegal, iss_valid);
        end
    endtask

    task automatic test_rm();
        @(negedge clk);
        iss_ready = 1'b1;
        frm = 3'b010;
        in_valid = 1'b1;
        in_instr = FADD_H;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iss_valid, iss_rm} !== {1'b1, 3'b010}) begin
            n_bad++;
            $display("FAIL dyn_rm: got vld=%b rm=%b want 1 010", iss_valid, iss_rm);
        end
        @(negedge clk);
        frm = 3'b101;
        in_valid = 1'b1;
        in_instr = FADD_H;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (iss_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dyn_rm_bad_hold: got vld=%b want 0", iss_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL dyn_rm_bad_illegal: got %b want 1", illegal);
        end
        @(negedge clk);
        frm = 3'b000;
        in_valid = 1'b1;
        in_instr = FADD_RM5;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (iss_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rm101_hold: got vld=%b want 0", iss_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL rm101_illegal: got %b want 1", illegal);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = FMADD_H;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iss_valid, iss_class, iss_rm, iss_rd} !== {1'b1, 3'd5, 3'b001, 5'd8}) begin
            n_bad++;
            $display("FAIL fused_static_rm: got vld=%b cls=%0d rm=%b rd=%0d want 1 5 001 8",
                     iss_valid, iss_class, iss_rm, iss_rd);
        end
    endtask

    task automatic test_classes();
        iss_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = b[i];
            #1;
            if (i > 0) begin
                n_cmp++;
                if ({iss_valid, iss_instr, iss_class, iss_rm} !== {1'b1, b[i-1], bc[i-1], 3'd0}) begin
                    n_bad++;
                    $display("FAIL class_%0d: got vld=%b instr=%h cls=%0d rm=%0d want 1 %h %0d 0",
                             i - 1, iss_valid, iss_instr, iss_class, iss_rm, b[i-1], bc[i-1]);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iss_valid, iss_instr, iss_class, iss_rm} !== {1'b1, b[4], bc[4], 3'd0}) begin
            n_bad++;
            $display("FAIL class_4: got vld=%b instr=%h cls=%0d rm=%0d want 1 %h %0d 0",
                     iss_valid, iss_instr, iss_class, iss_rm, b[4], bc[4]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = FEQ_H_X5;
        @(negedge clk);
        in_instr = ADDI_X6;
        #1;
        n_cmp++;
        if ({iss_valid, iss_class, iss_rd} !== {1'b1, 3'd4, 5'd5}) begin
            n_bad++;
            $display("FAIL feq_issue: got vld=%b cls=%0d rd=%0d want 1 4 5", iss_valid, iss_class, iss_rd);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef FPU_SCOREBOARD_EN
        n_cmp++;
        if ({iss_valid, iss_instr, sb_pending} !== {1'b0, ADDI_X6, 32'h20}) begin
            n_bad++;
            $display("FAIL addi_stall: got vld=%b instr=%h sb=%h want 0 %h 00000020",
                     iss_valid, iss_instr, sb_pending, ADDI_X6);
        end
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd = 5'd5;
        #1;
        n_cmp++;
        if ({iss_valid, sb_pending} !== {1'b0, 32'h20}) begin
            n_bad++;
            $display("FAIL stall_during_wb: got vld=%b sb=%h want 0 00000020", iss_valid, sb_pending);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iss_valid, iss_instr, sb_pending} !== {1'b1, ADDI_X6, 32'd0}) begin
            n_bad++;
            $display("FAIL addi_after_wb: got vld=%b instr=%h sb=%h want 1 %h 0",
                     iss_valid, iss_instr, sb_pending, ADDI_X6);
        end
`else
        n_cmp++;
        if ({iss_valid, iss_instr, sb_pending} !== {1'b1, ADDI_X6, 32'd0}) begin
            n_bad++;
            $display("FAIL addi_no_stall: got vld=%b instr=%h sb=%h want 1 %h 0",
                     iss_valid, iss_instr, sb_pending, ADDI_X6);
        end
`endif
        @(negedge clk);
        #1;
        n_cmp++;
        if (iss_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL addi_consumed: got vld=%b want 0", iss_valid);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = FLT_H_X7;
        @(negedge clk);
        in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        #1;
        n_cmp++;
        if ({iss_valid, iss_rd} !== {1'b1, 5'd7}) begin
            n_bad++;
            $display("FAIL flt_issue: got vld=%b rd=%0d want 1 7", iss_valid, iss_rd);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (sb_pending !== SB7) begin
            n_bad++;
            $display("FAIL set_wins: got sb=%h want %h", sb_pending, SB7);
        end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = a[i];
        end
        @(negedge clk);
        in_instr = 32'h00700393;
        flush = 1'b1;
        iss_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iss_valid, in_ready, iss_instr, illegal} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL flush_empty: got vld=%b rdy=%b instr=%h ill=%b want 0 1 0 0",
                     iss_valid, in_ready, iss_instr, illegal);
        end
        n_cmp++;
        if (sb_pending !== SB7) begin
            n_bad++;
            $display("FAIL flush_keeps_sb: got sb=%h want %h", sb_pending, SB7);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = FADD_S;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if ({illegal, iss_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL flushed_drop_quiet: got ill=%b vld=%b want 0 0", illegal, iss_valid);
        end
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (sb_pending !== 32'd0) begin
            n_bad++;
            $display("FAIL wb_clear_x7: got sb=%h want 0", sb_pending);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = FLT_H_X7;
        @(negedge clk);
        in_instr = a[0];
        @(negedge clk);
        iss_ready = 1'b0;
        in_instr = a[1];
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iss_valid, iss_instr, sb_pending} !== {1'b1, a[0], SB7}) begin
            n_bad++;
            $display("FAIL pre_reset_state: got vld=%b instr=%h sb=%h want 1 %h %h",
                     iss_valid, iss_instr, sb_pending, a[0], SB7);
        end
        #1;
        rst_l = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, iss_valid, illegal, iss_instr, iss_class, sb_pending} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b vld=%b ill=%b instr=%h cls=%0d sb=%h",
                     in_ready, iss_valid, illegal, iss_instr, iss_class, sb_pending);
        end
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({iss_valid, illegal, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL post_reset_idle: got vld=%b ill=%b rdy=%b want 0 0 1", iss_valid, illegal, in_ready);
        end
    endtask

    initial begin
        a[0] = 32'h00100093; a[1] = 32'h00200113; a[2] = 32'h00300193;
        a[3] = 32'h00400213; a[4] = 32'h00500293;
        b[0] = 32'h123454B7; bc[0] = 3'd2;
        b[1] = 32'h00309573; bc[1] = 3'd3;
        b[2] = 32'h00000010; bc[2] = 3'd6;
        b[3] = 32'h00000033; bc[3] = 3'd0;
        b[4] = 32'h00100093; bc[4] = 3'd1;

        test_reset();
        test_fill_order();
        test_flen();
        test_rm();
        test_classes();
        test_scoreboard();
        test_same_cycle();
        test_flush();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpu_issue_decode.md
# fpu_issue_decode

Parametrised instruction front-end for the half/single-precision FPU coprocessor. It buffers incoming 32-bit instructions in a DEPTH-entry queue and classifies the head entry (ADDI, LUI, CSR, FP compute, FP fused, custom reset). It resolves the FP rounding mode and drops illegal encodings. An integer-destination scoreboard stalls issue until late FPU integer results (compare, convert, move) have been written back. It sits between instruction fetch and the existing integer register file / CSR / FPU decode path.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- FLEN, 16, FP width; 16 accepts fmt=10 only, 32 accepts fmt=00 and fmt=10

Ports:
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  queue can accept; high iff count<DEPTH
- in_instr  in  32  instruction word
- flush  in  1  discard all queued entries
- iss_valid  out  1  head decoded, legal and hazard-free
- iss_ready  in  1  consumer accepts head
- iss_instr  out  32  head instruction
- iss_class  out  3  0 other, 1 ADDI, 2 LUI, 3 CSR, 4 FP compute, 5 FP fused, 6 reset (opcode 0010000)
- iss_rd / iss_rs1 / iss_rs2  out  5 each  instr[11:7] / [19:15] / [24:20]
- iss_rm  out  3  resolved rounding mode
- frm  in  3  dynamic rounding mode from the FPU CSR
- wb_valid  in  1  FPU integer result written back
- wb_rd  in  5  register of that writeback
- sb_pending  out  32  scoreboard bits; bit 0 always 0
- illegal  out  1  one-cycle pulse per dropped instruction

## Operation
- Decode by opcode [6:0]:
  - 0010011 → ADDI
  - 0110111 → LUI
  - 1110011 → CSR
  - 1010011 → FP compute
  - 1000011 / 1000111 / 1001011 / 1001111 → FP fused
  - 0010000 → reset
  - any other opcode → class 0, issued unchanged
- Illegal conditions:
  - FP class with fmt [26:25] not permitted by FLEN
  - FP class with rm=111 while frm ∈ {101,110,111}
  - FP class with funct3 ∈ {101,110}, when rounding applies
- Illegal head: never issued. It is popped in the cycle it is head, and `illegal` pulses in the following cycle.
- iss_rm:
  - funct3, when FP class and funct3≠111
  - frm, when FP class and funct3=111
  - 000 for all non-FP classes
- Integer-writing FP ops are OP-FP with funct5 ∈ {10100, 11000, 11100}.
- Scoreboard set:
  - When an integer-writing FP op is issued with rd≠0, set sb_pending[rd] at the issue edge.
  - wb_valid clears sb_pending[wb_rd].
  - If set and clear hit the same register in the same cycle, set wins.
- Integer sources:
  - rs1 for ADDI
  - rs1 for CSR with funct3=001
  - rs1 for OP-FP with funct5 ∈ {11010, 11110}
- Hazard: the head's integer source is pending, or the head's rd (rd≠0) is pending. A hazard forces iss_valid=0.
- Handshake:
  - Head pops on iss_valid & iss_ready.
  - Head fields are stable while iss_valid=1 and iss_ready=0.
- Push occurs on in_valid & in_ready. When full, no push occurs even if a pop happens in the same cycle.
- Flush:
  - Empties the queue and has priority over push and pop in the same cycle.
  - The scoreboard is not cleared by flush.
  - A drop being flushed does not raise `illegal`.

## Timing
- Reset values: queue empty, count=0, pointers=0, sb_pending=0, illegal=0, iss_valid=0, in_ready=1. All iss_* fields are 0 while empty.
- Reset asserted mid-operation: state clears immediately (asynchronous), with no illegal pulse.
- Latency: an instruction pushed at edge N is head from cycle N+1; iss_valid can be high at the earliest in N+1.
- Throughput: one issue per cycle when iss_ready is held high and there are no hazards.
- Write-through: a writeback at edge N clears the bit from cycle N+1, and a stalled head issues in cycle N+1.
- Pointer wrap: pointers wrap at DEPTH using log2(DEPTH) bits. Full and empty are distinguished by count.
- Outputs driven from registers: illegal and sb_pending. iss_* and in_ready are combinational from the state registers.

## Configuration
- FPU_SCOREBOARD_EN:
  - Defined: scoreboard and hazard stall as specified above.
  - Undefined: no scoreboard registers, sb_pending=0, and hazards never stall.

## Test plan
- DEPTH=4: push 5 instructions with iss_ready=0 → in_ready low after the 4th, the 5th is held. Set iss_ready=1 → issue in push order on consecutive cycles.
- FLEN=16:
  - FADD.S (0x0020F0D3, fmt=00) → not issued, illegal pulses one cycle after it reaches head.
  - FADD.H (0x0420F0D3) → issued as class 4.
- FP op with rm=111:
  - frm=010 → iss_rm=010.
  - frm=101 → dropped, illegal=1.
- FEQ.H x5 (funct5 10100) issued, then ADDI x6,x5,1 queued:
  - ADDI stalls and sb_pending[5]=1.
  - wb_valid with wb_rd=5 → ADDI issues on the next cycle, sb_pending=0.
- Same-cycle set and clear: issue FLT.H x7 while wb_valid with wb_rd=7 → sb_pending[7]=1.
- Flush and reset:
  - 3 queued entries plus flush with in_valid=1 → queue empty, nothing stored, sb_pending unchanged.
  - rst_l low mid-stream → all outputs at their reset values.
